divider_ctrl: RTL and testbench

Control unit for the iterative restoring divider. It sequences the N-bit datapath and the external iteration `Counter` (its `E`, `sclr` and `zC` pins) through load, shift and conditional subtract. It asserts `done` with a level handshake on `s`, and flags divide-by-zero. It sits between the top-level start/done interface and the divider datapath (A/Q shift register, B register, R register, subtractor/comparator).

---
 rtl/divider_ctrl.sv | 94 +++++++++
 tb/tb_divider_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/divider_ctrl.sv
// Sequencing FSM for the iterative restoring divider.
// It drives the A/Q, B and R registers, the iteration counter and the start/done/err handshake.
module divider_ctrl #(
  parameter int N = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic s_i,
  input  logic zero_div_i,
  input  logic cout_i,
  input  logic zc_i,
  output logic lab_o,
  output logic sclr_r_o,
  output logic er_o,
  output logic lr_o,
  output logic ea_o,
  output logic qbit_o,
  output logic ec_o,
  output logic sclr_c_o,
  output logic busy_o,
  output logic done_o,
  output logic err_o
);

  // The iteration count lives in the external counter, which is sized from N.
  if (N < 2) begin : g_n_too_small
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_SUB,
    S_DONE,
    S_ERR
  } state_e;

  state_e state_q, state_d;

  logic lab_q, sclr_r_q, ea_q, ec_q, sclr_c_q, busy_q, done_q, err_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (s_i) state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: state_d = zero_div_i ? S_ERR : S_SUB;
      S_SUB:   state_d = zc_i ? S_DONE : S_SHIFT;
      S_DONE:  if (!s_i) state_d = S_IDLE;
      S_ERR:   if (!s_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next state, so they match the current state.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      lab_q    <= 1'b0;
      sclr_r_q <= 1'b0;
      ea_q     <= 1'b0;
      ec_q     <= 1'b0;
      sclr_c_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lab_q    <= (state_d == S_LOAD);
      sclr_r_q <= (state_d == S_LOAD);
      sclr_c_q <= (state_d == S_LOAD);
      ea_q     <= (state_d == S_SUB);
      ec_q     <= (state_d == S_SUB);
      busy_q   <= (state_d == S_LOAD) || (state_d == S_SHIFT) || (state_d == S_SUB);
      done_q   <= (state_d == S_DONE);
      err_q    <= (state_d == S_ERR);
    end
  end

  // zero_div is only valid after the LOAD edge, so ER cannot be precomputed.
  assign er_o   = (state_q == S_SHIFT) && !zero_div_i;
  assign qbit_o = (state_q == S_SUB) && cout_i;
  assign lr_o   = (state_q == S_SUB) && cout_i;

  assign lab_o    = lab_q;
  assign sclr_r_o = sclr_r_q;
  assign ea_o     = ea_q;
  assign ec_o     = ec_q;
  assign sclr_c_o = sclr_c_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_divider_ctrl.sv
// Directed bench for divider_ctrl with a behavioural N=8 datapath and iteration counter.
`timescale 1ns/1ps
module tb_divider_ctrl;

  logic clk = 1'b0;
  logic reset, s;
  logic zero_div, cout, zc;
  logic lab, sclr_r, er, lr, ea, qbit, ec, sclr_c, busy, done, err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  divider_ctrl #(.N(8)) dut (
    .clk_i(clk), .reset_i(reset), .s_i(s), .zero_div_i(zero_div), .cout_i(cout), .zc_i(zc),
    .lab_o(lab), .sclr_r_o(sclr_r), .er_o(er), .lr_o(lr), .ea_o(ea), .qbit_o(qbit),
    .ec_o(ec), .sclr_c_o(sclr_c), .busy_o(busy), .done_o(done), .err_o(err)
  );

  // Datapath and counter model
  logic [7:0] dividend, divisor;
  logic [7:0] a_q, b_q;
  logic [8:0] r_q;
  logic [2:0] cnt_q;

  assign zero_div = (b_q == 8'd0);
  assign cout     = (r_q >= {1'b0, b_q});
  assign zc       = (cnt_q == 3'd7);

  always_ff @(posedge clk) begin
    if (lab) begin
      a_q <= dividend;
      b_q <= divisor;
    end else if (ea) begin
      a_q <= {a_q[6:0], qbit};
    end
    if (sclr_r)  r_q <= 9'd0;
    else if (lr) r_q <= r_q - {1'b0, b_q};
    else if (er) r_q <= {r_q[7:0], a_q[7]};
    if (sclr_c)  cnt_q <= 3'd0;
    else if (ec) cnt_q <= cnt_q + 3'd1;
  end

  wire [10:0] outs = {lab, sclr_r, er, lr, ea, qbit, ec, sclr_c, busy, done, err};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts an operation from IDLE (this cycle is cycle 0) and observes cycles 1..ncyc.
  task automatic run_op(input logic [7:0] dvd, input logic [7:0] dvs, input int ncyc,
                        output int done_cyc, output int err_cyc, output logic [7:0] qv,
                        output int lr_cnt, output int ea_cnt, output int ec_cnt,
                        output int er_cnt, output int busy_cnt, output int done_drop);
    dividend = dvd;
    divisor  = dvs;
    s = 1'b1;
    done_cyc = -1; err_cyc = -1; qv = 8'd0;
    lr_cnt = 0; ea_cnt = 0; ec_cnt = 0; er_cnt = 0; busy_cnt = 0; done_drop = 0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      if (ea) begin
        qv = {qv[6:0], qbit};
        ea_cnt++;
      end
      if (lr)   lr_cnt++;
      if (ec)   ec_cnt++;
      if (er)   er_cnt++;
      if (busy) busy_cnt++;
      if (done && done_cyc < 0) done_cyc = k;
      if (done_cyc >= 0 && !done) done_drop++;
      if (err && err_cyc < 0) err_cyc = k;
    end
  endtask

  int dc, ec_c, lrc, eac, ecc, erc, bc, dd;
  logic [7:0] qv;

  task automatic test_reset();
    reset = 1'b1;
    s = 1'b0;
    dividend = 8'd0;
    divisor = 8'd0;
    tick();
    tick();
    n_checks++;
    if (outs !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected %b", outs, 11'd0);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++;
      if (outs !== 11'd0) begin
        n_fail++;
        $display("FAIL idle_hold cycle %0d: got %b expected %b", k, outs, 11'd0);
      end
    end
  endtask

  task automatic test_div_100_7();
    run_op(8'd100, 8'd7, 22, dc, ec_c, qv, lrc, eac, ecc, erc, bc, dd);
    n_checks++;
    if (dc !== 18) begin n_fail++; $display("FAIL t2_done_cycle: got %0d expected 18", dc); end
    n_checks++;
    if (qv !== 8'b00001110) begin n_fail++; $display("FAIL t2_qbit_seq: got %b expected 00001110", qv); end
    n_checks++;
    if (a_q !== 8'd14) begin n_fail++; $display("FAIL t2_quotient: got %0d expected 14", a_q); end
    n_checks++;
    if (r_q !== 9'd2) begin n_fail++; $display("FAIL t2_remainder: got %0d expected 2", r_q); end
    n_checks++;
    if (bc !== 17) begin n_fail++; $display("FAIL t2_busy_cycles: got %0d expected 17", bc); end
    n_checks++;
    if (dd !== 0) begin n_fail++; $display("FAIL t2_done_hold: dropped %0d cycles expected 0", dd); end
    s = 1'b0;
    n_checks++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL t2_done_before_release: got %b expected 1", done); end
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL t2_done_release: got %b expected 0", done); end
  endtask

  task automatic test_div_255_1();
    run_op(8'd255, 8'd1, 20, dc, ec_c, qv, lrc, eac, ecc, erc, bc, dd);
    n_checks++;
    if (dc !== 18) begin n_fail++; $display("FAIL t3_done_cycle: got %0d expected 18", dc); end
    n_checks++;
    if (qv !== 8'hFF) begin n_fail++; $display("FAIL t3_qbit_seq: got %b expected 11111111", qv); end
    n_checks++;
    if (lrc !== 8) begin n_fail++; $display("FAIL t3_lr_pulses: got %0d expected 8", lrc); end
    n_checks++;
    if (ecc !== 8) begin n_fail++; $display("FAIL t3_ec_pulses: got %0d expected 8", ecc); end
    n_checks++;
    if (a_q !== 8'd255 || r_q !== 9'd0) begin
      n_fail++;
      $display("FAIL t3_result: got q=%0d r=%0d expected q=255 r=0", a_q, r_q);
    end
    s = 1'b0;
    tick();
  endtask

  task automatic test_div_by_zero();
    run_op(8'd37, 8'd0, 8, dc, ec_c, qv, lrc, eac, ecc, erc, bc, dd);
    n_checks++;
    if (ec_c !== 3) begin n_fail++; $display("FAIL t4_err_cycle: got %0d expected 3", ec_c); end
    n_checks++;
    if (dc !== -1) begin n_fail++; $display("FAIL t4_no_done: got %0d expected -1", dc); end
    n_checks++;
    if (eac + lrc + ecc + erc !== 0) begin
      n_fail++;
      $display("FAIL t4_no_enables: got ea=%0d lr=%0d ec=%0d er=%0d expected all 0", eac, lrc, ecc, erc);
    end
    s = 1'b0;
    n_checks++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL t4_err_held: got %b expected 1", err); end
    tick();
    n_checks++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL t4_err_release: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_op();
    int subs;
    subs = 0;
    dividend = 8'd200;
    divisor = 8'd9;
    s = 1'b1;
    for (int k = 1; k <= 30 && subs < 4; k++) begin
      tick();
      if (ea) subs++;
    end
    n_checks++;
    if (subs !== 4) begin n_fail++; $display("FAIL t5_reach_sub4: got %0d expected 4", subs); end
    reset = 1'b1;
    s = 1'b0;
    tick();
    reset = 1'b0;
    n_checks++;
    if (outs !== 11'd0) begin n_fail++; $display("FAIL t5_reset_outputs: got %b expected %b", outs, 11'd0); end
    run_op(8'd200, 8'd9, 18, dc, ec_c, qv, lrc, eac, ecc, erc, bc, dd);
    n_checks++;
    if (dc !== 18) begin n_fail++; $display("FAIL t5_done_cycle: got %0d expected 18", dc); end
    n_checks++;
    if (a_q !== 8'd22 || r_q !== 9'd2) begin
      n_fail++;
      $display("FAIL t5_result: got q=%0d r=%0d expected q=22 r=2", a_q, r_q);
    end
    s = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    run_op(8'd100, 8'd7, 18, dc, ec_c, qv, lrc, eac, ecc, erc, bc, dd);
    n_checks++;
    if (dc !== 18) begin n_fail++; $display("FAIL t6_first_done: got %0d expected 18", dc); end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!done || lab || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL t6_no_restart: got %0d bad cycles expected 0", bad); end
    s = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL t6_idle_after_release: got done=%b expected 0", done); end
    run_op(8'd50, 8'd50, 18, dc, ec_c, qv, lrc, eac, ecc, erc, bc, dd);
    n_checks++;
    if (dc !== 18) begin n_fail++; $display("FAIL t6_second_done: got %0d expected 18", dc); end
    n_checks++;
    if (a_q !== 8'd1 || r_q !== 9'd0) begin
      n_fail++;
      $display("FAIL t6_result: got q=%0d r=%0d expected q=1 r=0", a_q, r_q);
    end
    s = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    s = 1'b0;
    test_reset();
    test_div_100_7();
    test_div_255_1();
    test_div_by_zero();
    test_reset_mid_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
